// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size and FSM state encodings,
// plus the decode that folds the reserved size code onto a word access.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_e;

    // Size code 2'b11 is reserved and behaves exactly like a word access.
    function automatic size_e decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends a load lane from a memory word,
// and merges right-aligned store data into the addressed lane of a memory word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    size_e       sz;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign sz = size_e'(size);

    always_comb begin
        lane_b    = word[{offset, 3'b000} +: 8];
        lane_h    = offset[1] ? word[31:16] : word[15:0];
        load_data = word;
        case (sz)
            SZ_B:    load_data = uns ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_H:    load_data = uns ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_data = word;
        endcase
    end

    // Low offset bits below the access size are ignored, giving natural alignment.
    always_comb begin
        merged = word;
        case (sz)
            SZ_B: merged[{offset, 3'b000} +: 8] = wdata[7:0];
            SZ_H: begin
                if (offset[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit with read-modify-write for sub-word stores on a word-wide memory.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses instead of aligning them.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int MEMORY_TYPE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_e      state;
    state_e      state_n;
    size_e       req_sz;
    logic        accept;
    logic        capture;
    logic        mis_req;

    logic        we_q;
    size_e       size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rd_q;
    logic        mis_q;

    logic [31:0] load_data;
    logic [31:0] merged;

    assign req_sz = decode_size(req_size);

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_req = ((req_sz == SZ_H) && req_addr[0]) ||
                     ((req_sz == SZ_W) && (req_addr[1:0] != 2'b00));
`else
    assign mis_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        capture    = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (mis_req) begin
                        state_n = RESP;
                    end else if (!req_we) begin
                        state_n = READ;
                    end else if (req_sz == SZ_W) begin
                        state_n = WRITE;
                    end else begin
                        state_n = READ;
                    end
                end
            end
            READ: begin
                // A registered-output memory needs one more cycle before mem_rd is valid.
                if (MEMORY_TYPE == 0) begin
                    capture = 1'b1;
                    state_n = we_q ? WRITE : RESP;
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                capture = 1'b1;
                state_n = we_q ? WRITE : RESP;
            end
            WRITE: begin
                mem_we  = 1'b1;
                state_n = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            mis_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_sz;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rd_q    <= '0;
                mis_q   <= mis_req;
            end
            if (capture) begin
                rd_q <= mem_rd;
            end
        end
    end

    lsu_align u_align (
        .size      (size_q),
        .uns       (uns_q),
        .offset    (addr_q[1:0]),
        .word      (rd_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    assign mem_a      = {2'b00, addr_q[31:2]};
    assign mem_wd     = mem_we ? merged : '0;
    assign resp_rdata = (resp_valid && !we_q && !mis_q) ? load_data : '0;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = resp_valid && mis_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed and random bench for lsu_rmw: one instance per memory type, each with its own
// word memory model; expected responses are queued at issue and checked on resp_valid.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid0, req_valid1;
    logic        req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        ready0, resp_valid0, mis0, mem_we0;
    logic [31:0] rdata0, mem_a0, mem_wd0, mem_rd0;
    logic        ready1, resp_valid1, mis1, mem_we1;
    logic [31:0] rdata1, mem_a1, mem_wd1, mem_rd1;

    logic [31:0] mem0 [16];
    logic [31:0] mem1 [16];
    logic [31:0] refm [2][16];
    logic [31:0] rdreg1;
    int          wecnt0, wecnt1;
    logic        pl_en0, pl_en1;
    logic [3:0]  pl_addr;
    logic [31:0] pl_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          wes;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    lsu_rmw #(.MEMORY_TYPE(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(ready0),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid0),
        .resp_rdata(rdata0), .misalign(mis0), .mem_we(mem_we0), .mem_a(mem_a0),
        .mem_wd(mem_wd0), .mem_rd(mem_rd0)
    );

    lsu_rmw #(.MEMORY_TYPE(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(ready1),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid1),
        .resp_rdata(rdata1), .misalign(mis1), .mem_we(mem_we1), .mem_a(mem_a1),
        .mem_wd(mem_wd1), .mem_rd(mem_rd1)
    );

    // Memory 0 reads combinationally; memory 1 has a registered read port.
    assign mem_rd0 = mem0[mem_a0[3:0]];
    assign mem_rd1 = rdreg1;

    always @(posedge clk) begin
        if (pl_en0) begin
            mem0[pl_addr] <= pl_data;
        end else if (mem_we0) begin
            mem0[mem_a0[3:0]] <= mem_wd0;
            wecnt0 <= wecnt0 + 1;
        end
    end

    always @(posedge clk) begin
        rdreg1 <= mem1[mem_a1[3:0]];
        if (pl_en1) begin
            mem1[pl_addr] <= pl_data;
        end else if (mem_we1) begin
            mem1[mem_a1[3:0]] <= mem_wd1;
            wecnt1 <= wecnt1 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [31:0] a);
        logic [31:0] s;
        if (sz == 2'd0) begin
            s = w >> {a[1:0], 3'b000};
            return uns ? {24'd0, s[7:0]} : {{24{s[7]}}, s[7:0]};
        end else if (sz == 2'd1) begin
            s = w >> {a[1], 4'b0000};
            return uns ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
        end
        return w;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [31:0] a, input logic [31:0] d);
        logic [31:0] mask;
        logic [4:0]  sh;
        if (sz == 2'd0) begin
            sh   = {a[1:0], 3'b000};
            mask = 32'h0000_00FF << sh;
        end else if (sz == 2'd1) begin
            sh   = {a[1], 4'b0000};
            mask = 32'h0000_FFFF << sh;
        end else begin
            sh   = 5'd0;
            mask = 32'hFFFF_FFFF;
        end
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        if (sz == 2'd1) return a[0];
        if (sz[1]) return a[1:0] != 2'b00;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic preload(input int sel, input int idx, input logic [31:0] d);
        @(negedge clk);
        pl_addr = idx[3:0];
        pl_data = d;
        if (sel == 0) pl_en0 = 1'b1; else pl_en1 = 1'b1;
        @(negedge clk);
        pl_en0 = 1'b0;
        pl_en1 = 1'b0;
        refm[sel][idx] = d;
    endtask

    task automatic do_req(input int sel, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] got_rdata);
        exp_t e;
        int   lat;
        int   wc_start;
        logic got;
        e.mis   = m_mis(sz, addr);
        e.rdata = (e.mis || we) ? 32'd0 : m_load(refm[sel][addr[5:2]], sz, uns, addr);
        e.wes   = (we && !e.mis) ? 1 : 0;
        if (e.mis)          e.lat = 1;
        else if (!we)       e.lat = 2 + sel;
        else if (sz[1])     e.lat = 2;
        else                e.lat = 3 + sel;
        sb.push_back(e);
        got_rdata = 32'hDEAD_BEEF;

        @(negedge clk);
        check("req_ready_idle", (sel != 0) ? ready1 : ready0, 1);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        if (sel == 0) req_valid0 = 1'b1; else req_valid1 = 1'b1;
        wc_start = (sel != 0) ? wecnt1 : wecnt0;
        @(negedge clk);
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat <= 10) begin
            if ((sel != 0) ? resp_valid1 : resp_valid0) begin
                got = 1'b1;
                e = sb.pop_front();
                got_rdata = (sel != 0) ? rdata1 : rdata0;
                check("resp_rdata", got_rdata, e.rdata);
                check("misalign", (sel != 0) ? mis1 : mis0, e.mis);
                check("latency", lat, e.lat);
                check("mem_we_pulses", ((sel != 0) ? wecnt1 : wecnt0) - wc_start, e.wes);
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        check("resp_seen", got, 1'b1);
        if (!got) sb = {};
        @(negedge clk);
        check("resp_one_cycle", (sel != 0) ? resp_valid1 : resp_valid0, 1'b0);
        if (we && !e.mis) begin
            refm[sel][addr[5:2]] = m_merge(refm[sel][addr[5:2]], sz, addr, wd);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] ra;
        int          seen;
        int          cnt;
        reset = 1'b1;
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        pl_en0 = 1'b0; pl_en1 = 1'b0; pl_addr = '0; pl_data = '0;
        wecnt0 = 0; wecnt1 = 0;
        repeat (2) @(negedge clk);

        check("rst_req_ready", ready0, 1'b1);
        check("rst_resp_valid", resp_valid0, 1'b0);
        check("rst_resp_rdata", rdata0, 32'd0);
        check("rst_misalign", mis0, 1'b0);
        check("rst_mem_we", mem_we0, 1'b0);
        check("rst_mem_a", mem_a0, 32'd0);
        check("rst_mem_wd", mem_wd0, 32'd0);
        check("rst_mem_we_mt1", mem_we1, 1'b0);
        reset = 1'b0;

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) preload(s, i, $urandom);
            preload(s, 1, 32'hAABB_CCDD);

            do_req(s, 1'b1, 2'd2, 1'b0, 32'h08, 32'h1234_5678, r);
            check("sw_mem_word2", (s != 0) ? mem1[2] : mem0[2], 32'h1234_5678);
            do_req(s, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, r);
            check("lw_0x08", r, 32'h1234_5678);

            do_req(s, 1'b1, 2'd0, 1'b0, 32'h06, 32'hFFFF_FF11, r);
            check("sb_merge_word1", (s != 0) ? mem1[1] : mem0[1], 32'hAA11_CCDD);
            do_req(s, 1'b0, 2'd0, 1'b0, 32'h07, 32'h0, r);
            check("lb_0x07", r, 32'hFFFF_FFAA);
            do_req(s, 1'b0, 2'd0, 1'b1, 32'h07, 32'h0, r);
            check("lbu_0x07", r, 32'h0000_00AA);
            do_req(s, 1'b0, 2'd1, 1'b0, 32'h04, 32'h0, r);
            check("lh_0x04", r, 32'hFFFF_CCDD);
            do_req(s, 1'b0, 2'd1, 1'b1, 32'h06, 32'h0, r);
            check("lhu_0x06", r, 32'h0000_AA11);

            do_req(s, 1'b1, 2'd1, 1'b0, 32'h0E, 32'h0000_BEEF, r);
            do_req(s, 1'b1, 2'd3, 1'b0, 32'h10, 32'h0BAD_F00D, r);
            do_req(s, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, r);
            check("reserved_size_word", r, 32'h0BAD_F00D);

            do_req(s, 1'b1, 2'd2, 1'b0, 32'h0A, 32'hCAFE_F00D, r);
`ifdef LSU_MISALIGN_TRAP_EN
            check("misaligned_sw_no_write", (s != 0) ? mem1[2] : mem0[2], 32'h1234_5678);
`else
            check("misaligned_sw_word2", (s != 0) ? mem1[2] : mem0[2], 32'hCAFE_F00D);
`endif
            do_req(s, 1'b0, 2'd2, 1'b0, 32'hFFFF_FF08, 32'h0, r);
            check("high_addr_lw", r, refm[s][2]);
        end

        for (int n = 0; n < 40; n++) begin
            ra = 32'($urandom_range(0, 63));
            do_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, $urandom, r);
        end

        for (int i = 0; i < 16; i++) begin
            check("final_mem0", mem0[i], refm[0][i]);
            check("final_mem1", mem1[i], refm[1][i]);
        end

        // Reset landing in the WRITE cycle of a byte store must abandon it cleanly.
        preload(0, 5, 32'h5566_7788);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h14; req_wdata = 32'h99;
        req_valid0 = 1'b1;
        @(negedge clk);
        req_valid0 = 1'b0;
        cnt = 0;
        while (!mem_we0 && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("write_cycle_reached", mem_we0, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_mid_mem_we", mem_we0, 1'b0);
        check("rst_mid_req_ready", ready0, 1'b1);
        check("rst_mid_mem_wd", mem_wd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid0) seen++;
        end
        check("rst_mid_no_resp", seen, 0);
        check("rst_mid_mem_unchanged", mem0[5], 32'h5566_7788);
        check("rst_mid_idle_ready", ready0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_rmw.md
LSU_RMW -- requirements
Module: lsu_rmw

Interface
REQ-001 The block SHALL have parameter MEMORY_TYPE, default 0, meaning data-memory read latency: 0 = combinational read, 1 = BSRAM with registered output (one cycle).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port req_valid  input  1  core presents a load/store request.
REQ-005 The block SHALL have port req_ready  output  1  block can accept a request.
REQ-006 The block SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 The block SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
REQ-008 The block SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 The block SHALL have port req_addr  input  32  byte address.
REQ-010 The block SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 The block SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 The block SHALL have port resp_rdata  output  32  extended load data; 0 for stores.
REQ-013 The block SHALL have port misalign  output  1  valid with resp_valid; request was misaligned.
REQ-014 The block SHALL have ports mem_we (output 1), mem_a (output 32), mem_wd (output 32) and mem_rd (input 32), forming the word-indexed data-memory port, with mem_a = {2'b00, addr[31:2]}.

Function
REQ-015 The FSM SHALL have states IDLE, READ, WAIT, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 When req_valid && req_ready, the block SHALL latch all req_* fields and leave IDLE on the next edge.
REQ-017 Routing SHALL be: load -> READ; word store -> WRITE; byte/half store -> READ (read-modify-write).
REQ-018 In READ, mem_a SHALL be driven and mem_we SHALL be 0; with MEMORY_TYPE=0 the block captures mem_rd in READ; with MEMORY_TYPE=1 it goes to WAIT and captures mem_rd there.
REQ-019 After the capture, a load SHALL go to RESP and a sub-word store SHALL go to WRITE.
REQ-020 In WRITE, mem_we SHALL be 1 for exactly one cycle with mem_wd = merged word, then the FSM goes to RESP.
REQ-021 The merged word SHALL replace only the addressed byte lane (addr[1:0]) or half lane (addr[1]) of the captured word with the low bits of req_wdata.
REQ-022 Load extraction SHALL select the lane by addr[1:0], then sign- or zero-extend it to 32 bits per req_unsigned.
REQ-023 In RESP, resp_valid SHALL be 1 for one cycle, then the FSM returns to IDLE; there SHALL be no back-pressure on the response.
REQ-024 Latency from the accept edge to resp_valid SHALL be: word store 2; load 2 (MEMORY_TYPE=0) or 3 (MEMORY_TYPE=1); sub-word store 3 or 4 respectively.
REQ-025 mem_we SHALL be decoded combinationally from state == WRITE only; no other state writes memory.
REQ-026 Addresses with bits [31:6] nonzero SHALL pass through unchanged; wrap-around is the memory's responsibility.

Reset
REQ-027 Reset SHALL force state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, misalign=0, mem_we=0, mem_a=0, mem_wd=0, and clear all latched fields.
REQ-028 Reset asserted mid-operation, including in WRITE, SHALL drop mem_we immediately and abandon the request with no response.

Configuration
REQ-029 With LSU_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL go directly to RESP with misalign=1, resp_rdata=0 and no memory access.
REQ-030 Without LSU_MISALIGN_TRAP_EN, misalign SHALL be tied 0 and misaligned low address bits SHALL be ignored, giving natural alignment.

Structure
REQ-031 Package lsu_pkg SHALL hold the size enum (SZ_B, SZ_H, SZ_W) and the FSM state enum.
REQ-032 Sub-module lsu_align SHALL be purely combinational and perform lane extract/extend and lane merge; the FSM and registers SHALL stay in lsu_rmw.

Verification
REQ-033 Word store 0x12345678 to 0x08, then word load 0x08 -> mem_we pulses once at mem_a=2; load returns 0x12345678.
REQ-034 Preload word[1]=0xAABBCCDD; byte store 0x11 to 0x06 -> single write of 0xAA11CCDD; mem_we high exactly 1 cycle.
REQ-035 With word[1]=0xAABBCCDD: lb 0x07 -> 0xFFFFFFAA; lbu 0x07 -> 0x000000AA; lh 0x04 -> 0xFFFFCCDD.
REQ-036 Repeat REQ-033 to REQ-035 with MEMORY_TYPE=1 -> identical data; resp_valid one cycle later for loads and sub-word stores.
REQ-037 Word store to 0x0A with LSU_MISALIGN_TRAP_EN -> misalign=1, resp_rdata=0, mem_we never asserted; without the macro -> write lands at word 2.
REQ-038 Reset asserted in the WRITE cycle of a byte store -> mem_we drops at once, memory is unchanged, resp_valid is never seen, and req_ready=1.
